// File: rtl/disp_btn_ctrl_pkg.sv
// Shared definitions for the display/button front-panel peripheral:
// register addresses, the all-off segment pattern and a width helper.
package disp_btn_ctrl_pkg;

    typedef enum logic [1:0] {
        DISP_VAL = 2'd0,
        DISP_CFG = 2'd1,
        BTN_LVL  = 2'd2,
        BTN_EVT  = 2'd3
    } reg_addr_t;

    localparam logic [7:0] BLANK_SEG = 8'hFF;

    // Counter width for a limit, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/disp_btn_ctrl_hex7seg.sv
// Hex nibble to 7-segment pattern, active-low, bit0..6 = segments a..g.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/disp_btn_ctrl.sv
// Memory-mapped front panel: multiplexed N-digit 7-segment driver with
// per-digit blanking and decimal points, plus N debounced buttons with sticky press events.
module disp_btn_ctrl
    import disp_btn_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int N_BTN        = 2,
    parameter int REFRESH_DIV  = 100000,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int DATA_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                we,
    input  logic [1:0]          addr,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    input  logic [N_BTN-1:0]    btn,
    output logic [7:0]          disp,
    output logic [N_DIGITS-1:0] disp_sel
);

    localparam int SCAN_W = clog2_min1(REFRESH_DIV);
    localparam int IDX_W  = clog2_min1(N_DIGITS);
    localparam int DB_W   = clog2_min1(DEBOUNCE_CYC);

    logic                  wr_en;
    logic                  rd_en;
    logic [4*N_DIGITS-1:0] val;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [N_BTN-1:0]      lvl;
    logic [N_BTN-1:0]      rise;
    logic [N_BTN-1:0]      evt;
    logic [N_BTN-1:0]      evt_clr;
    logic [DATA_W-1:0]     rd_data;
    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            cur_nib;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic                  unused_bits;

    assign wr_en       = sel & we;
    assign rd_en       = sel & ~we;
    assign unused_bits = ^data_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val   <= '0;
            dp    <= '0;
            blank <= '0;
        end else if (wr_en) begin
            case (reg_addr_t'(addr))
                DISP_VAL: val <= data_in[4*N_DIGITS-1:0];
                DISP_CFG: begin
                    dp    <= data_in[N_DIGITS-1:0];
                    blank <= data_in[8 +: N_DIGITS];
                end
                default: ;
            endcase
        end
    end

    // A press landing in the same cycle as its clear keeps the event set.
    assign evt_clr = (wr_en && reg_addr_t'(addr) == BTN_EVT) ? data_in[N_BTN-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) evt <= '0;
        else     evt <= (evt & ~evt_clr) | rise;
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr_t'(addr))
            DISP_VAL: rd_data[4*N_DIGITS-1:0] = val;
            DISP_CFG: begin
                rd_data[N_DIGITS-1:0] = dp;
                rd_data[8 +: N_DIGITS] = blank;
            end
            BTN_LVL:  rd_data[N_BTN-1:0] = lvl;
            BTN_EVT:  rd_data[N_BTN-1:0] = evt;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        data_out <= '0;
        else if (rd_en) data_out <= rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign cur_nib    = val[{idx, 2'b00} +: 4];
    assign sel_onehot = ~(N_DIGITS'(1) << idx);

    hex7seg u_hex (
        .nibble (cur_nib),
        .seg    (seg)
    );

    // Blanked digits keep their time slot but drive no segments and no enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp     <= BLANK_SEG;
            disp_sel <= '1;
        end else if (blank[idx]) begin
            disp     <= BLANK_SEG;
            disp_sel <= '1;
        end else begin
            disp     <= {~dp[idx], seg};
            disp_sel <= sel_onehot;
        end
    end

    for (genvar b = 0; b < N_BTN; b++) begin : g_db
        logic            sync1;
        logic            sync2;
        logic            lvl_q;
        logic            settle;
        logic [DB_W-1:0] cnt;

        assign settle = (sync2 != lvl_q) && (cnt == DB_W'(DEBOUNCE_CYC - 1));

        // The stability count only runs while the synchronised input disagrees with the level.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                lvl_q <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= btn[b];
                sync2 <= sync1;
                if (sync2 == lvl_q || settle) cnt <= '0;
                else                          cnt <= cnt + 1'b1;
                if (settle) lvl_q <= sync2;
            end
        end

        assign lvl[b]  = lvl_q;
        assign rise[b] = settle & sync2;
    end

endmodule

// File: tb/tb_disp_btn_ctrl.sv
// Directed, scoreboard-driven bench for disp_btn_ctrl with a short refresh
// and debounce period so every behaviour is reached in a few hundred cycles.
module tb_disp_btn_ctrl;

    localparam int N_DIGITS     = 4;
    localparam int N_BTN        = 2;
    localparam int REFRESH_DIV  = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int DATA_W       = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                sel;
    logic                we;
    logic [1:0]          addr;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic [N_BTN-1:0]    btn;
    logic [7:0]          disp;
    logic [N_DIGITS-1:0] disp_sel;

    int n_vec = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    disp_btn_ctrl #(
        .N_DIGITS     (N_DIGITS),
        .N_BTN        (N_BTN),
        .REFRESH_DIV  (REFRESH_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .DATA_W       (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .btn      (btn),
        .disp     (disp),
        .disp_sel (disp_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("[TB] FAIL scoreboard_empty: got %h required a queued value", obs);
        end else begin
            tag = tag_q.pop_front();
            e   = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("[TB] FAIL %s: got %h required %h", tag, obs, e);
            end
        end
    endtask

    // One bus cycle: the access is taken at the next rising edge.
    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d);
        sel     = 1'b1;
        we      = w;
        addr    = a;
        data_in = d;
        tick();
        sel     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic readReg(input logic [1:0] a, input string tag, input logic [31:0] e);
        pushExpect(tag, e);
        applyStimulus(1'b0, a, 32'h0);
        tick();
        checkOutput(data_out);
    endtask

    task automatic waitSlotStart(input string tag);
        bit                  found;
        logic [N_DIGITS-1:0] prev;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = disp_sel;
            tick();
            if (disp_sel == 4'hE && prev != 4'hE) found = 1'b1;
        end
        n_vec++;
        assert (found) else begin
            n_err++;
            $error("[TB] FAIL %s: got no digit0 slot start, required one within 40 cycles", tag);
        end
    endtask

    // Five slots of four cycles each, starting at a digit-0 slot, wrapping back to digit 0.
    task automatic scanCheck(input string tag, input logic [3:0][11:0] slots);
        for (int s = 0; s < 5; s++)
            for (int c = 0; c < REFRESH_DIV; c++)
                pushExpect($sformatf("%s_s%0d_c%0d", tag, s, c), {20'h0, slots[s % 4]});
        for (int k = 0; k < 5 * REFRESH_DIV; k++) begin
            checkOutput({20'h0, disp_sel, disp});
            tick();
        end
    endtask

    // Press a button, then let a bus write land on the exact edge its level rises.
    task automatic pressWithWrite(input int b, input logic [1:0] a, input logic [31:0] d);
        btn[b] = 1'b1;
        for (int i = 1; i < DEBOUNCE_CYC + 2; i++) tick();
        applyStimulus(1'b1, a, d);
    endtask

    initial begin
        sel = 1'b0; we = 1'b0; addr = '0; data_in = '0; btn = '0;
        rst = 1'b1;
        tick();
        tick();

        pushExpect("rst_disp", 32'hFF);      checkOutput({24'h0, disp});
        pushExpect("rst_disp_sel", 32'hF);   checkOutput({28'h0, disp_sel});
        pushExpect("rst_data_out", 32'h0);   checkOutput(data_out);
        rst = 1'b0;

        applyStimulus(1'b1, 2'd0, 32'h10A8);
        readReg(2'd0, "val_readback", 32'h10A8);
        for (int i = 0; i < 5; i++) tick();

        #2;
        rst = 1'b1;
        #1;
        pushExpect("async_rst_disp", 32'hFF);    checkOutput({24'h0, disp});
        pushExpect("async_rst_disp_sel", 32'hF); checkOutput({28'h0, disp_sel});
        pushExpect("async_rst_data_out", 32'h0); checkOutput(data_out);
        tick();
        rst = 1'b0;
        readReg(2'd0, "val_after_rst", 32'h0);

        $display("[TB] scan with VAL=10A8, CFG=0");
        applyStimulus(1'b1, 2'd0, 32'h10A8);
        applyStimulus(1'b1, 2'd1, 32'h0);
        waitSlotStart("sync_plain");
        scanCheck("scan_plain", {12'h7F9, 12'hBC0, 12'hD88, 12'hE80});

        $display("[TB] scan with dp on digit0, digit1 blanked");
        applyStimulus(1'b1, 2'd1, 32'h201);
        readReg(2'd1, "cfg_readback", 32'h201);
        waitSlotStart("sync_cfg");
        scanCheck("scan_cfg", {12'h7F9, 12'hBC0, 12'hFFF, 12'hE00});

        $display("[TB] debounce glitch and press on btn0");
        sel = 1'b1; we = 1'b0; addr = 2'd2;
        tick();
        tick();
        btn[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pushExpect("glitch_lvl", 32'h0);
            tick();
            checkOutput(data_out);
        end
        btn[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            pushExpect("glitch_settle_lvl", 32'h0);
            tick();
            checkOutput(data_out);
        end
        sel = 1'b0;
        readReg(2'd3, "glitch_evt", 32'h0);

        sel = 1'b1; we = 1'b0; addr = 2'd2;
        tick();
        btn[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            pushExpect($sformatf("press_lvl_t%0d", i), (i >= DEBOUNCE_CYC + 3) ? 32'h1 : 32'h0);
            tick();
            checkOutput(data_out);
        end
        sel = 1'b0;
        btn[0] = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        readReg(2'd3, "press_evt", 32'h1);
        readReg(2'd2, "release_lvl", 32'h0);

        $display("[TB] event set/clear collisions");
        pressWithWrite(1, 2'd3, 32'h1);
        readReg(2'd3, "evt_clear_other_set_new", 32'h2);
        pressWithWrite(0, 2'd3, 32'h1);
        readReg(2'd3, "evt_set_wins", 32'h3);

        readReg(2'd2, "lvl_both_held", 32'h3);
        applyStimulus(1'b1, 2'd2, 32'h0);
        readReg(2'd2, "lvl_write_ignored", 32'h3);
        applyStimulus(1'b1, 2'd3, 32'h2);
        readReg(2'd3, "evt_w1c", 32'h1);

        btn[0] = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        readReg(2'd2, "lvl_btn1_only", 32'h2);
        for (int i = 0; i < 3; i++) tick();
        pushExpect("data_out_hold", 32'h2);
        checkOutput(data_out);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
